key_sched_timer: RTL and testbench

KEY_SCHED_TIMER -- requirements
Module: key_sched_timer

---
 rtl/key_sched_pkg.sv | 34 +++
 rtl/flex_counter.sv | 42 ++++
 rtl/key_sched_timer.sv | 133 +++++++++++++
 tb/tb_key_sched_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_sched_pkg.sv
// Shared types and constants for the AES key-schedule round timer.
package key_sched_pkg;

    // Rounds per key size
    localparam int unsigned ROUNDS_AES128 = 10;
    localparam int unsigned ROUNDS_AES192 = 12;
    localparam int unsigned ROUNDS_AES256 = 14;

    // Width of the per-round cycle counter (CYC_PER_ROUND <= 15)
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    typedef enum logic [1:0] {
        MODE_AES128 = 2'b00,
        MODE_AES192 = 2'b01,
        MODE_AES256 = 2'b10,
        MODE_RSVD   = 2'b11
    } ks_mode_e;

    // Round count for a key size; reserved falls back to AES-128 (never latched)
    function automatic int unsigned rounds_for_mode(input ks_mode_e m);
        case (m)
            MODE_AES192: return ROUNDS_AES192;
            MODE_AES256: return ROUNDS_AES256;
            default:     return ROUNDS_AES128;
        endcase
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrapping cycle counter: counts 0..rollover_val-1 while enabled, sync clear.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] next_count_c,
    output logic                    rollover_flag_c
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] last_val;

    // Last value before wrap, and wrap/clear next-count selection
    always_comb begin
        last_val        = rollover_val - NUM_CNT_BITS'(1);
        rollover_flag_c = (count_q == last_val);
        next_count_c    = count_q;
        if (clear) begin
            next_count_c = '0;
        end else if (count_enable) begin
            if (rollover_flag_c) begin
                next_count_c = '0;
            end else begin
                next_count_c = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= next_count_c;
        end
    end

endmodule

// File: rtl/key_sched_timer.sv
// Round timer for AES key expansion: paces rounds, flags completion.
module key_sched_timer
    import key_sched_pkg::*;
#(
    parameter int unsigned CYC_PER_ROUND = 1,
    parameter int unsigned RND_BITS      = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                abort,
    output logic                busy,
    output logic                round_tick,
    output logic [RND_BITS-1:0] round_idx,
    output logic                key_done,
    output logic                mode_err
);

    localparam logic [CNT_W-1:0]    CYC_ROLL  = CNT_W'(CYC_PER_ROUND);
    localparam logic [CNT_W-1:0]    CYC_LAST  = CNT_W'(CYC_PER_ROUND - 1);
    localparam logic [RND_BITS-1:0] LAST_RST  = RND_BITS'(ROUNDS_AES128 - 32'd1);

    ks_state_e           state_q, state_d;
    logic [RND_BITS-1:0] round_idx_q, round_idx_d;
    logic [RND_BITS-1:0] last_rnd_q, last_rnd_d;
    logic                busy_q, busy_d;
    logic                round_tick_q, round_tick_d;
    logic                key_done_q, key_done_d;
    logic                mode_err_q, mode_err_d;

    logic                cnt_clear_c;
    logic                cnt_en_c;
    logic [CNT_W-1:0]    cnt_next_c;
    logic                cnt_wrap_c;
    logic                tick_c;

    // Per-round cycle counter
    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_cyc_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear           (cnt_clear_c),
        .count_enable    (cnt_en_c),
        .rollover_val    (CYC_ROLL),
        .next_count_c    (cnt_next_c),
        .rollover_flag_c (cnt_wrap_c)
    );

    assign tick_c = (state_q == ST_RUN) && cnt_wrap_c;

    // Next-state, round index and latched round limit
    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        last_rnd_d  = last_rnd_q;
        mode_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                round_idx_d = '0;
                if (start) begin
                    if (mode == MODE_RSVD) begin
                        mode_err_d = 1'b1;
                    end else begin
                        last_rnd_d = RND_BITS'(rounds_for_mode(ks_mode_e'(mode)) - 32'd1);
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abort wins over a coincident round_tick
                    state_d     = ST_IDLE;
                    round_idx_d = '0;
                end else if (tick_c) begin
                    if (round_idx_q == last_rnd_q) begin
                        state_d = ST_DONE;
                    end else begin
                        round_idx_d = round_idx_q + RND_BITS'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                round_idx_d = '0;
            end
            default: begin
                state_d     = ST_IDLE;
                round_idx_d = '0;
            end
        endcase
    end

    // Counter runs only in RUN and restarts from 0 on every entry into RUN
    assign cnt_en_c    = (state_q == ST_RUN);
    assign cnt_clear_c = (state_q != ST_RUN) || (state_d != ST_RUN);

    // Registered outputs derived from next state so they align with the state
    always_comb begin
        busy_d       = (state_d == ST_RUN);
        key_done_d   = (state_d == ST_DONE);
        round_tick_d = (state_d == ST_RUN) && (cnt_next_c == CYC_LAST);
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            round_idx_q  <= '0;
            last_rnd_q   <= LAST_RST;
            busy_q       <= 1'b0;
            round_tick_q <= 1'b0;
            key_done_q   <= 1'b0;
            mode_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_idx_q  <= round_idx_d;
            last_rnd_q   <= last_rnd_d;
            busy_q       <= busy_d;
            round_tick_q <= round_tick_d;
            key_done_q   <= key_done_d;
            mode_err_q   <= mode_err_d;
        end
    end

    assign busy       = busy_q;
    assign round_tick = round_tick_q;
    assign round_idx  = round_idx_q;
    assign key_done   = key_done_q;
    assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_key_sched_timer.sv
// Scoreboard bench for key_sched_timer: model predicts pulses per run.
module tb_key_sched_timer;

    localparam int unsigned CYC = 2;
    localparam int unsigned RB  = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [1:0]    mode;
    logic          abort;
    logic          busy;
    logic          round_tick;
    logic [RB-1:0] round_idx;
    logic          key_done;
    logic          mode_err;

    always #5 clk = ~clk;

    key_sched_timer #(
        .CYC_PER_ROUND (CYC),
        .RND_BITS      (RB)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .busy       (busy),
        .round_tick (round_tick),
        .round_idx  (round_idx),
        .key_done   (key_done),
        .mode_err   (mode_err)
    );

    // kind: 0 = round_tick, 1 = key_done, 2 = mode_err
    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    ev_t exp_q[$];
    int  cyc       = 0;
    int  n_vec     = 0;
    int  n_err     = 0;
    int  run_start = -1000;
    int  run_end   = -1000;
    int  done_cyc  = -1000;
    int  last_idx  = 0;

    function automatic int rounds_of(input logic [1:0] m);
        return (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
    endfunction

    function automatic int exp_busy(input int t);
        return (run_start <= t && t <= run_end) ? 1 : 0;
    endfunction

    function automatic int exp_idx(input int t);
        if (run_start <= t && t <= run_end) return (t - run_start) / int'(CYC);
        if (t == done_cyc) return last_idx;
        return 0;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        run_start = -1000;
        run_end   = -1000;
        done_cyc  = -1000;
        exp_q.delete();
    endtask

    // Reference behaviour for inputs sampled at edge k (interval k-1 was current)
    task automatic model_eval(input logic s, input logic [1:0] m, input logic a);
        int  k;
        int  r;
        ev_t e;
        k = cyc;
        if (n_rst !== 1'b1) return;
        if (run_start <= k - 1 && k - 1 <= run_end) begin
            if (a) begin
                while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= k)
                    exp_q.delete(exp_q.size() - 1);
                run_end  = k - 1;
                done_cyc = k - 1;
            end
        end else if (!(run_start <= k - 1 && k - 1 <= done_cyc)) begin
            if (s) begin
                if (m == 2'b11) begin
                    e = '{2, k, 0};
                    exp_q.push_back(e);
                end else begin
                    r = rounds_of(m);
                    for (int i = 0; i < r; i++) begin
                        e = '{0, k + (i + 1) * int'(CYC) - 1, i};
                        exp_q.push_back(e);
                    end
                    e = '{1, k + r * int'(CYC), r - 1};
                    exp_q.push_back(e);
                    run_start = k;
                    run_end   = k + r * int'(CYC) - 1;
                    done_cyc  = k + r * int'(CYC);
                    last_idx  = r - 1;
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge sample them, update model
    task automatic cycle(input logic s, input logic [1:0] m, input logic a);
        start = s;
        mode  = m;
        abort = a;
        @(posedge clk);
        cyc++;
        model_eval(s, m, a);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_round_tick"}, int'(round_tick), 0);
        chk({tag, "_round_idx"},  int'(round_idx),  0);
        chk({tag, "_key_done"},   int'(key_done),   0);
        chk({tag, "_mode_err"},   int'(mode_err),   0);
    endtask

    // Monitor: per-cycle busy/index, and pop expected pulse events
    always @(negedge clk) begin
        int  kind;
        ev_t e;
        if (n_rst === 1'b1) begin
            chk("busy", int'(busy), exp_busy(cyc));
            chk("round_idx", int'(round_idx), exp_idx(cyc));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_event kind=%0d want_cyc=%0d now=%0d", e.kind, e.cyc, cyc);
            end
            if (round_tick || key_done || mode_err) begin
                kind = round_tick ? 0 : (key_done ? 1 : 2);
                chk("pulse_onehot", int'(round_tick) + int'(key_done) + int'(mode_err), 1);
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse kind=%0d cyc=%0d idx=%0d", kind, cyc, round_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_idx", int'(round_idx), e.idx);
                end
            end
        end
    end

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        abort = 1'b0;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0, 2'b00, 1'b0);
        n_rst = 1'b1;
        cycle(1'b0, 2'b00, 1'b0);

        // AES-128 with mode flipped to AES-256 and spurious starts mid-run
        cycle(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 10 * int'(CYC) + 3; i++)
            cycle((i < 10 * int'(CYC)) && (i % 3 == 0), 2'b10, 1'b0);

        // AES-256
        cycle(1'b1, 2'b10, 1'b0);
        repeat (14 * CYC + 2) cycle(1'b0, 2'b00, 1'b0);

        // AES-192
        cycle(1'b1, 2'b01, 1'b0);
        repeat (12 * CYC + 2) cycle(1'b0, 2'b00, 1'b0);

        // Reserved mode rejected
        cycle(1'b1, 2'b11, 1'b0);
        repeat (3) cycle(1'b0, 2'b00, 1'b0);

        // Abort coincident with the round-5 tick
        cycle(1'b1, 2'b00, 1'b0);
        repeat (6 * CYC - 1) cycle(1'b0, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 1'b0);

        // Abort in IDLE has no effect
        repeat (2) cycle(1'b0, 2'b00, 1'b1);

        // Chaining: start/abort in DONE ignored, start in following IDLE accepted
        cycle(1'b1, 2'b01, 1'b0);
        repeat (12 * CYC) cycle(1'b0, 2'b00, 1'b0);
        cycle(1'b1, 2'b00, 1'b1);
        cycle(1'b1, 2'b00, 1'b0);
        repeat (10 * CYC + 2) cycle(1'b0, 2'b00, 1'b0);

        // Reset asserted mid-run
        cycle(1'b1, 2'b10, 1'b0);
        repeat (7) cycle(1'b0, 2'b00, 1'b0);
        #2;
        n_rst = 1'b0;
        model_clear();
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk);
        cyc++;
        #1;
        repeat (2) cycle(1'b0, 2'b00, 1'b0);
        n_rst = 1'b1;
        cycle(1'b0, 2'b00, 1'b0);

        // Randomized traffic
        repeat (400) begin
            cycle(1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 24) == 0));
        end

        // Drain and confirm nothing left pending
        repeat (40) cycle(1'b0, 2'b00, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
